// File: rtl/int_ctrl_6801.sv
// Interrupt request arbiter for the 6801 core: synchronises NMI/IRQ, latches
// edge/pulse sources, applies I-mask and fixed priority, issues a one-shot vector.
//
// state   | meaning
// IDLE    | waiting for a poll; int_pending reflects unmasked requests
// ISSUE   | iv_ctrl carries the winning vector for one un-held cycle
// SERVICE | vector fetch in progress; waiting for ack to retire the source
module int_ctrl_6801 (
    input  logic       clk,
    input  logic       rst,
    input  logic       hold,
    input  logic       nmi_n,
    input  logic       irq_n,
    input  logic       icf_req,
    input  logic       ocf_req,
    input  logic       tof_req,
    input  logic       sci_req,
    input  logic       swi,
    input  logic       i_mask,
    input  logic       poll,
    input  logic       ack,
    output logic [3:0] iv_ctrl,
    output logic       int_pending
);

    localparam logic [3:0] latch_iv = 4'd0;
    localparam logic [3:0] reset_iv = 4'd1;
    localparam logic [3:0] nmi_iv   = 4'd2;
    localparam logic [3:0] swi_iv   = 4'd3;
    localparam logic [3:0] irq_iv   = 4'd4;
    localparam logic [3:0] icf_iv   = 4'd5;
    localparam logic [3:0] ocf_iv   = 4'd6;
    localparam logic [3:0] tof_iv   = 4'd7;
    localparam logic [3:0] sci_iv   = 4'd8;

    typedef enum logic [1:0] {IDLE, ISSUE, SERVICE} state_t;

    state_t     state, state_nxt;
    logic [3:0] iv_nxt, svc, svc_nxt, winner;
    logic       ack_pend, ack_pend_nxt;
    logic       nmi_s1, nmi_s2, nmi_s3, nmi_edge;
    logic       irq_s1, irq_s2, irq;
    logic       nmi_lat, swi_lat, rst_flag;
    logic       any_req, clr_svc;
    logic       clr_rst, clr_nmi, clr_swi;

    assign nmi_edge = nmi_s3 & ~nmi_s2;
    assign irq      = ~irq_s2;

    always_comb begin
        winner = latch_iv;
        if (rst_flag)                 winner = reset_iv;
        else if (nmi_lat)             winner = nmi_iv;
        else if (swi_lat)             winner = swi_iv;
        else if (!i_mask && irq)      winner = irq_iv;
        else if (!i_mask && icf_req)  winner = icf_iv;
        else if (!i_mask && ocf_req)  winner = ocf_iv;
        else if (!i_mask && tof_req)  winner = tof_iv;
        else if (!i_mask && sci_req)  winner = sci_iv;
    end

    assign any_req = rst_flag | nmi_lat | swi_lat |
                     (~i_mask & (irq | icf_req | ocf_req | tof_req | sci_req));

    always_comb begin
        state_nxt    = state;
        iv_nxt       = iv_ctrl;
        svc_nxt      = svc;
        ack_pend_nxt = 1'b0;
        clr_svc      = 1'b0;
        int_pending  = 1'b0;
        case (state)
            IDLE: begin
                int_pending = any_req;
                if (poll && any_req) begin
                    iv_nxt    = winner;
                    svc_nxt   = winner;
                    state_nxt = ISSUE;
                end
            end
            ISSUE: begin
                iv_nxt       = latch_iv;
                ack_pend_nxt = ack;
                state_nxt    = SERVICE;
            end
            SERVICE: begin
                if (ack || ack_pend) begin
                    clr_svc   = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Latch clears only take effect on an un-held cycle
    assign clr_rst = clr_svc & ~hold & (svc == reset_iv);
    assign clr_nmi = clr_svc & ~hold & (svc == nmi_iv);
    assign clr_swi = clr_svc & ~hold & (svc == swi_iv);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            iv_ctrl  <= latch_iv;
            svc      <= reset_iv;
            ack_pend <= 1'b0;
            rst_flag <= 1'b1;
            swi_lat  <= 1'b0;
        end else if (!hold) begin
            state    <= state_nxt;
            iv_ctrl  <= iv_nxt;
            svc      <= svc_nxt;
            ack_pend <= ack_pend_nxt;
            rst_flag <= rst_flag & ~clr_rst;
            swi_lat  <= swi | (swi_lat & ~clr_swi);
        end
    end

    // Synchronisers and the NMI set path run regardless of hold
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            nmi_s1  <= 1'b1;
            nmi_s2  <= 1'b1;
            nmi_s3  <= 1'b1;
            irq_s1  <= 1'b1;
            irq_s2  <= 1'b1;
            nmi_lat <= 1'b0;
        end else begin
            nmi_s1  <= nmi_n;
            nmi_s2  <= nmi_s1;
            nmi_s3  <= nmi_s2;
            irq_s1  <= irq_n;
            irq_s2  <= irq_s1;
            nmi_lat <= nmi_edge | (nmi_lat & ~clr_nmi);
        end
    end

endmodule

// File: tb/tb_int_ctrl_6801.sv
// Scoreboard bench for int_ctrl_6801: stimulus pushes expected vector issues,
// a negedge monitor pops and checks each iv_ctrl pulse and its length.
module tb_int_ctrl_6801;

    localparam logic [3:0] LATCH = 4'd0;
    localparam logic [3:0] RESET = 4'd1;
    localparam logic [3:0] NMI   = 4'd2;
    localparam logic [3:0] SWI   = 4'd3;
    localparam logic [3:0] IRQ   = 4'd4;
    localparam logic [3:0] OCF   = 4'd6;
    localparam logic [3:0] SCI   = 4'd8;

    logic clk = 1'b0;
    logic rst, hold, nmi_n, irq_n, icf_req, ocf_req, tof_req, sci_req;
    logic swi, i_mask, poll, ack;
    logic [3:0] iv_ctrl;
    logic int_pending;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic [3:0] vec;
        int         len;
    } exp_t;
    exp_t exp_q[$];

    int         run_len = 0;
    logic [3:0] run_vec = LATCH;

    int_ctrl_6801 dut (
        .clk(clk), .rst(rst), .hold(hold), .nmi_n(nmi_n), .irq_n(irq_n),
        .icf_req(icf_req), .ocf_req(ocf_req), .tof_req(tof_req), .sci_req(sci_req),
        .swi(swi), .i_mask(i_mask), .poll(poll), .ack(ack),
        .iv_ctrl(iv_ctrl), .int_pending(int_pending)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            @(negedge clk);
        end
    endtask

    task automatic expect_iv(input logic [3:0] v, input int len);
        exp_t e;
        e.vec = v;
        e.len = len;
        exp_q.push_back(e);
    endtask

    task automatic do_poll();
        poll = 1'b1;
        tick();
        poll = 1'b0;
    endtask

    task automatic do_ack();
        ack = 1'b1;
        tick();
        ack = 1'b0;
    endtask

    // Monitor: an issue is a run of non-latch iv_ctrl cycles
    always @(negedge clk) begin
        if (iv_ctrl !== LATCH) begin
            if (run_len == 0) run_vec = iv_ctrl;
            run_len++;
        end else if (run_len != 0) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_issue", int'(run_vec), int'(LATCH));
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("iv_vector", int'(run_vec), int'(e.vec));
                chk("iv_length", run_len, e.len);
            end
            run_len = 0;
        end
    end

    initial begin
        rst = 1'b1; hold = 1'b0; nmi_n = 1'b1; irq_n = 1'b1;
        icf_req = 1'b0; ocf_req = 1'b0; tof_req = 1'b0; sci_req = 1'b0;
        swi = 1'b0; i_mask = 1'b1; poll = 1'b0; ack = 1'b0;
        tick(2);
        chk("reset_iv_ctrl", int'(iv_ctrl), int'(LATCH));
        chk("reset_pending", int'(int_pending), 1);
        rst = 1'b0;

        // Reset vector after release
        tick(3);
        expect_iv(RESET, 1);
        do_poll();
        tick();
        chk("service_pending_low", int'(int_pending), 0);
        do_ack();
        chk("after_reset_ack", int'(int_pending), 0);

        // IRQ masked, then unmasked
        irq_n = 1'b0;
        tick(3);
        chk("irq_masked", int'(int_pending), 0);
        i_mask = 1'b0;
        #1;
        chk("irq_unmasked", int'(int_pending), 1);
        expect_iv(IRQ, 1);
        do_poll();
        tick();
        do_ack();

        // NMI beats IRQ and OCF, then IRQ, then OCF
        ocf_req = 1'b1;
        nmi_n = 1'b0;
        tick(3);
        chk("nmi_pending", int'(int_pending), 1);
        nmi_n = 1'b1;
        expect_iv(NMI, 1);
        do_poll();
        tick();
        do_ack();
        expect_iv(IRQ, 1);
        do_poll();
        tick();
        do_ack();
        chk("ocf_still_pending", int'(int_pending), 1);
        irq_n = 1'b1;
        tick(2);
        expect_iv(OCF, 1);
        do_poll();
        tick();
        do_ack();
        ocf_req = 1'b0;
        i_mask = 1'b1;
        #1;
        chk("all_clear", int'(int_pending), 0);

        // New NMI edge on the ack cycle of NMI service: set wins
        nmi_n = 1'b0;
        tick(3);
        nmi_n = 1'b1;
        expect_iv(NMI, 1);
        do_poll();
        tick();
        nmi_n = 1'b0;
        tick(2);
        do_ack();
        chk("nmi_set_wins", int'(int_pending), 1);
        expect_iv(NMI, 1);
        do_poll();
        tick();
        do_ack();
        nmi_n = 1'b1;
        tick();
        chk("nmi_retired", int'(int_pending), 0);

        // SWI and NMI together; SWI acked early, during ISSUE
        nmi_n = 1'b0;
        swi = 1'b1;
        tick();
        swi = 1'b0;
        tick(2);
        nmi_n = 1'b1;
        chk("swi_nmi_pending", int'(int_pending), 1);
        expect_iv(NMI, 1);
        do_poll();
        tick();
        do_ack();
        expect_iv(SWI, 1);
        do_poll();
        do_ack();
        tick();
        chk("swi_early_ack", int'(int_pending), 0);

        // SCI issue stretched by hold; NMI edge during hold is kept
        i_mask = 1'b0;
        sci_req = 1'b1;
        #1;
        chk("sci_pending", int'(int_pending), 1);
        expect_iv(SCI, 4);
        do_poll();
        hold = 1'b1;
        nmi_n = 1'b0;
        tick(3);
        hold = 1'b0;
        tick();
        do_ack();
        sci_req = 1'b0;
        #1;
        chk("nmi_during_hold", int'(int_pending), 1);
        nmi_n = 1'b1;
        expect_iv(NMI, 1);
        do_poll();
        tick();
        do_ack();
        chk("hold_seq_clear", int'(int_pending), 0);

        // Async reset mid-SERVICE with swi_lat set
        swi = 1'b1;
        tick();
        swi = 1'b0;
        expect_iv(SWI, 1);
        do_poll();
        tick();
        #2;
        rst = 1'b1;
        #1;
        chk("async_rst_iv", int'(iv_ctrl), int'(LATCH));
        chk("async_rst_pending", int'(int_pending), 1);
        tick();
        rst = 1'b0;
        tick(2);
        expect_iv(RESET, 1);
        do_poll();
        tick();
        do_ack();
        chk("swi_discarded", int'(int_pending), 0);

        tick(3);
        chk("scoreboard_empty", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/int_ctrl_6801.md
# int_ctrl_6801

Interrupt request arbiter for the 6801 core. It synchronises the external NMI and IRQ pins and collects the SWI, timer (ICF/OCF/TOF) and SCI requests. It applies the CCR I mask and fixed priority, and at each instruction-boundary poll issues a one-shot `iv_type` command to the vector register stage (`iv_ctrl` input of the IV control block). It sits directly upstream of that block and handshakes with the microsequencer through `poll`/`ack`.

## Interface
Parameters: none.

Ports:
- `clk`  in  1  system clock; all state changes on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `hold`  in  1  pipeline freeze, shared with all core register stages.
- `nmi_n`  in  1  external NMI, active low, asynchronous, falling-edge triggered.
- `irq_n`  in  1  external IRQ1, active low, asynchronous, level sensitive.
- `icf_req`, `ocf_req`, `tof_req`, `sci_req`  in  1 each  synchronous level requests from timer/SCI, already gated by their enable bits.
- `swi`  in  1  one-cycle pulse from the sequencer when SWI executes.
- `i_mask`  in  1  CCR I bit.
- `poll`  in  1  sequencer samples interrupts at an instruction boundary.
- `ack`  in  1  sequencer pulse: vector fetch started, the serviced request is taken.
- `iv_ctrl`  out  `iv_type`  vector command to the IV stage; `latch_iv` when idle.
- `int_pending`  out  1  an unmasked request is waiting; also serves as the WAI wake signal.

## Operation
- Synchronisers:
  - `nmi_n` passes through s1→s2→s3; edge = s3 & ~s2.
  - `irq_n` passes through two flops; `irq` = ~sync2.
- Latched sources:
  - `rst_flag` is set by reset.
  - `nmi_lat` is set on edge.
  - `swi_lat` is set by a `swi` pulse.
- Level sources: `irq`, `icf_req`, `ocf_req`, `tof_req`, `sci_req`. These are masked when `i_mask`=1. They are never cleared here; the ISR clears them at the source.
- Priority, highest first: reset > nmi > swi > irq > icf > ocf > tof > sci. This maps to `reset_iv`, `nmi_iv`, `swi_iv`, `irq_iv`, `icf_iv`, `ocf_iv`, `tof_iv`, `sci_iv`.
- FSM states:
  - IDLE: `int_pending` = OR of unmasked sources.
    - `poll` & `int_pending` → register the winner into `iv_ctrl` and into `svc`, then go to ISSUE.
    - `poll` with nothing pending: no action.
    - `ack` is ignored.
  - ISSUE (exactly one un-held cycle): `iv_ctrl` holds the winner. Next state is SERVICE, and `iv_ctrl` returns to `latch_iv`.
  - SERVICE: `int_pending`=0; `poll` is ignored.
    - `ack` clears the latch named by `svc` (`rst_flag`, `nmi_lat` or `swi_lat`; level sources untouched) and returns the FSM to IDLE.
    - `ack` in ISSUE is treated as arriving in SERVICE on the next cycle.
- Simultaneous events:
  - A new NMI edge in the same cycle as the `ack` that clears `nmi_lat`: the set wins, so `nmi_lat` stays 1.
  - A `swi` pulse with `ack` clearing `swi_lat`: the set wins.
  - `swi` and `nmi` in the same cycle: both latch; NMI is serviced first.
- A level request that deasserts after the poll capture is still serviced; its vector is already issued.
- `hold`=1 freezes the FSM, `svc`, `iv_ctrl`, `rst_flag` and `swi_lat`. `iv_ctrl` therefore stays valid until the IV stage consumes it.
  - Synchronisers and the `nmi_lat` set path keep running under `hold`, so no NMI edge is lost.
  - The `nmi_lat` clear path is frozen under `hold`.
- Reset mid-operation: any state → IDLE immediately. All pending latches are discarded except `rst_flag`, which is set.

## Timing
- Reset values:
  - nmi s1/s2/s3 = 1; irq syncs = 1.
  - `nmi_lat`=0, `swi_lat`=0, `rst_flag`=1.
  - state IDLE, `iv_ctrl`=`latch_iv`, `svc`=`reset_iv`.
  - `int_pending`=1, because reset is pending.
- `nmi_n` falls before edge k:
  - s2=0 after k+1; `nmi_lat`=1 after k+2.
  - `int_pending` is high in the cycle after k+2.
- `irq_n` low before edge k: `int_pending` rises after k+1, provided `i_mask`=0.
- `swi` high at edge k: `swi_lat`=1 after k.
- `int_pending` is combinational from the registered sources, `i_mask` and the state.
- `poll` at edge k with a pending request:
  - `iv_ctrl`=winner after k, held for one un-held cycle.
  - The IV stage's `iv` updates at edge k+1.
- Issue latency from `poll` to `iv` valid is 2 edges. `hold` cycles extend it one-for-one.

## Test plan
- Reset release, then `poll` at cycle 3 → `iv_ctrl`=`reset_iv` for one cycle. After `ack`, `int_pending`=0 with no other sources.
- `irq_n`=0 with `i_mask`=1 → `int_pending` stays 0. Clear `i_mask` → `int_pending` high within 0 cycles. Then `poll` → `irq_iv`.
- `irq_n`=0 and `ocf_req`=1, plus an NMI falling edge 1 cycle before `poll`+2 → `nmi_iv` issued. After `ack`, the next `poll` → `irq_iv`; `ocf` still pending.
- A second NMI edge arriving on the exact `ack` cycle of NMI service → `nmi_lat` remains 1, and the next `poll` → `nmi_iv` again.
- `poll` with `sci_req`=1, then `hold`=1 for 3 cycles → `iv_ctrl`=`sci_iv` is held for 4 cycles total, then `latch_iv`. An NMI edge during the hold is latched.
- `rst` asserted asynchronously mid-SERVICE with `swi_lat`=1 → immediately IDLE with `iv_ctrl`=`latch_iv`, `swi_lat`=0, and the next `poll` → `reset_iv`.
